// File: rtl/scnn_pkg.sv
// rtl/scnn_pkg.sv - shared SCNN load-path constants and tile types
package scnn_pkg;

    localparam int DATA_W         = 32;
    localparam int TILE_DIM       = 4;
    localparam int BEATS_PER_TILE = 2 * TILE_DIM;

    localparam logic [1:0] SCNN_FLAG_WB   = 2'b01;
    localparam logic [1:0] SCNN_FLAG_LOAD = 2'b10;

    typedef logic [TILE_DIM-1:0][DATA_W-1:0] tile_t;

endpackage

// File: rtl/scnn_tile_collector_if.sv
// rtl/scnn_tile_collector_if.sv - response stream in, tile pair handshake out
interface scnn_tile_collector_if #(
    parameter int DATA_W   = 32,
    parameter int TILE_DIM = 4
);

    logic                                data_rvalid_i;
    logic [DATA_W-1:0]                   data_rdata_i;
    logic [TILE_DIM-1:0][DATA_W-1:0]     tile_a_o;
    logic [TILE_DIM-1:0][DATA_W-1:0]     tile_b_o;
    logic                                tile_valid_o;
    logic                                tile_ready_i;

    // master: LSU response side plus MAC-array consumer
    modport master (
        output data_rvalid_i, data_rdata_i, tile_ready_i,
        input  tile_a_o, tile_b_o, tile_valid_o
    );

    modport slave (
        input  data_rvalid_i, data_rdata_i, tile_ready_i,
        output tile_a_o, tile_b_o, tile_valid_o
    );

endinterface

// File: rtl/scnn_tile_pingpong.sv
// rtl/scnn_tile_pingpong.sv - two-entry A/B tile store with push/pop pointers
module scnn_tile_pingpong
    import scnn_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int TILE_DIM = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            wr_en,
    input  logic                            wr_is_a,
    input  logic [$clog2(TILE_DIM)-1:0]     wr_row,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            push,
    input  logic                            pop,
    output logic [TILE_DIM-1:0][DATA_W-1:0] rd_a,
    output logic [TILE_DIM-1:0][DATA_W-1:0] rd_b,
    output logic                            rd_valid,
    output logic                            wr_full
);

    logic [TILE_DIM-1:0][DATA_W-1:0] a_q [2];
    logic [TILE_DIM-1:0][DATA_W-1:0] a_d [2];
    logic [TILE_DIM-1:0][DATA_W-1:0] b_q [2];
    logic [TILE_DIM-1:0][DATA_W-1:0] b_d [2];
    logic [1:0] full_q, full_d;
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (clr) begin
            full_d   = '0;
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_is_a) a_d[wr_sel_q][wr_row] = wr_data;
                else         b_d[wr_sel_q][wr_row] = wr_data;
            end
            // push and pop never target the same entry: push needs it empty, pop needs it full
            if (pop) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end
            if (push) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '{default: '0};
            b_q      <= '{default: '0};
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    assign rd_a     = a_q[rd_sel_q];
    assign rd_b     = b_q[rd_sel_q];
    assign rd_valid = full_q[rd_sel_q];
    assign wr_full  = full_q[wr_sel_q];

endmodule

// File: rtl/scnn_tile_collector.sv
// rtl/scnn_tile_collector.sv - de-interleaves gemm4x4 load responses into A/B tile pairs
module scnn_tile_collector
    import scnn_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int TILE_DIM = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          scnn_flag_i,
    input  logic                gemm4x4_active_i,
    input  logic                im2col_active_i,
    scnn_tile_collector_if.slave bus,
    output logic                stall_o,
    output logic [CNT_W-1:0]    tile_cnt_o,
    output logic                overflow_o
);

    logic [2:0]       beat_q, beat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             clr, collect, accept, push, pop;

    assign clr     = (scnn_flag_i == SCNN_FLAG_LOAD);
    assign collect = bus.data_rvalid_i & gemm4x4_active_i & ~im2col_active_i;
    assign accept  = collect & ~stall_o & ~clr;
    assign push    = accept & (beat_q == 3'(BEATS_PER_TILE - 1));
    assign pop     = bus.tile_valid_o & bus.tile_ready_i & ~clr;

    always_comb begin
        beat_d = beat_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (clr) begin
            beat_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (accept) beat_d = beat_q + 3'd1;
            if (push)   cnt_d  = cnt_q + CNT_W'(1);
            // writeback/maxpool traffic while stalled is not ours and is not an overflow
            if (collect && stall_o) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // beat[0] selects operand (B on even, A on odd), beat[2:1] selects the row
    scnn_tile_pingpong #(
        .DATA_W   (DATA_W),
        .TILE_DIM (TILE_DIM)
    ) u_pingpong (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_en    (accept),
        .wr_is_a  (beat_q[0]),
        .wr_row   (beat_q[2:1]),
        .wr_data  (bus.data_rdata_i),
        .push     (push),
        .pop      (pop),
        .rd_a     (bus.tile_a_o),
        .rd_b     (bus.tile_b_o),
        .rd_valid (bus.tile_valid_o),
        .wr_full  (stall_o)
    );

    assign tile_cnt_o = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_scnn_tile_collector.sv
// tb/tb_scnn_tile_collector.sv - directed and randomized checks of scnn_tile_collector
module tb_scnn_tile_collector;
    import scnn_pkg::*;

    typedef struct packed {
        tile_t a;
        tile_t b;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  scnn_flag;
    logic        gemm_active;
    logic        im2col_active;
    logic        stall;
    logic [15:0] tile_cnt;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    pair_t       mq[$];
    logic [31:0] part[$];
    int          m_cnt;
    logic        m_ovf;

    scnn_tile_collector_if #(.DATA_W(32), .TILE_DIM(4)) bus ();

    scnn_tile_collector #(.DATA_W(32), .TILE_DIM(4), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .scnn_flag_i      (scnn_flag),
        .gemm4x4_active_i (gemm_active),
        .im2col_active_i  (im2col_active),
        .bus              (bus),
        .stall_o          (stall),
        .tile_cnt_o       (tile_cnt),
        .overflow_o       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        part.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Reference: a FIFO of at most two finished tile pairs plus a list of pending words
    task automatic model_step(input logic [1:0] flag, input logic gem, input logic im,
                              input logic rv, input logic [31:0] d, input logic rdy);
        pair_t p;
        logic  ours, full_before;
        if (flag == 2'b10) begin
            model_clear();
        end else begin
            ours        = rv && gem && !im;
            full_before = (mq.size() == 2);
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (ours && full_before) begin
                m_ovf = 1'b1;
            end else if (ours) begin
                part.push_back(d);
                if (part.size() == 8) begin
                    for (int r = 0; r < 4; r++) begin
                        p.b[r] = part[2*r];
                        p.a[r] = part[2*r+1];
                    end
                    mq.push_back(p);
                    part.delete();
                    m_cnt = (m_cnt + 1) % 65536;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 128'(bus.tile_valid_o), 128'(mq.size() > 0));
        chk({tag, "_stall"}, 128'(stall), 128'(mq.size() == 2));
        chk({tag, "_cnt"}, 128'(tile_cnt), 128'(m_cnt[15:0]));
        chk({tag, "_ovf"}, 128'(overflow), 128'(m_ovf));
        if (mq.size() > 0) begin
            chk({tag, "_tile_a"}, bus.tile_a_o, mq[0].a);
            chk({tag, "_tile_b"}, bus.tile_b_o, mq[0].b);
        end
    endtask

    task automatic step(input logic [1:0] flag, input logic gem, input logic im,
                        input logic rv, input logic [31:0] d, input logic rdy);
        scnn_flag         = flag;
        gemm_active       = gem;
        im2col_active     = im;
        bus.data_rvalid_i = rv;
        bus.data_rdata_i  = d;
        bus.tile_ready_i  = rdy;
        model_step(flag, gem, im, rv, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic rdy);
        step(2'b00, 1'b1, 1'b0, 1'b1, d, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(2'b00, 1'b1, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        rst               = 1'b1;
        scnn_flag         = 2'b00;
        gemm_active       = 1'b0;
        im2col_active     = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = '0;
        bus.tile_ready_i  = 1'b0;
        model_clear();

        #12;
        chk("reset_valid", 128'(bus.tile_valid_o), 128'(0));
        chk("reset_stall", 128'(stall), 128'(0));
        chk("reset_cnt", 128'(tile_cnt), 128'(0));
        chk("reset_ovf", 128'(overflow), 128'(0));
        chk("reset_tile_a", bus.tile_a_o, 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single tile
        step(2'b10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int r = 0; r < 4; r++) begin
            beat(32'hB0 + 32'(r), 1'b1);
            beat(32'hA0 + 32'(r), 1'b1);
        end
        chk("single_valid", 128'(bus.tile_valid_o), 128'(1));
        chk("single_a", bus.tile_a_o, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("single_b", bus.tile_b_o, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        chk("single_cnt", 128'(tile_cnt), 128'(1));
        check_all("single");
        idle(1'b1);
        check_all("single_pop");

        // back-pressure
        for (int i = 0; i < 16; i++) beat($urandom, 1'b0);
        chk("bp_stall", 128'(stall), 128'(1));
        check_all("bp_full");
        beat(32'hDEADBEEF, 1'b0);
        chk("bp_ovf", 128'(overflow), 128'(1));
        check_all("bp_drop");
        idle(1'b1);
        chk("bp_stall_drop", 128'(stall), 128'(0));
        check_all("bp_pop1");
        idle(1'b1);
        check_all("bp_pop2");
        chk("bp_ovf_sticky", 128'(overflow), 128'(1));

        // simultaneous push of tile 1 and pop of tile 0
        step(2'b10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) beat($urandom, 1'b0);
        for (int i = 0; i < 7; i++) beat($urandom, 1'b0);
        check_all("sim_pre");
        beat($urandom, 1'b1);
        check_all("sim_edge");
        chk("sim_cnt", 128'(tile_cnt), 128'(2));
        idle(1'b1);
        check_all("sim_drain");

        // filtering
        step(2'b10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1);
        step(2'b00, 1'b1, 1'b1, 1'b1, 32'h22222222, 1'b1);
        check_all("filter");
        chk("filter_ovf", 128'(overflow), 128'(0));
        for (int i = 0; i < 8; i++) beat(32'h100 + 32'(i), 1'b0);
        chk("filter_a", bus.tile_a_o, {32'h107, 32'h105, 32'h103, 32'h101});
        chk("filter_b", bus.tile_b_o, {32'h106, 32'h104, 32'h102, 32'h100});
        check_all("filter_tile");

        // restart mid-tile with a response in the clearing cycle
        step(2'b10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) beat(32'hBAD0 + 32'(i), 1'b0);
        step(2'b10, 1'b1, 1'b0, 1'b1, 32'hBADF, 1'b0);
        for (int i = 0; i < 8; i++) beat(32'h200 + 32'(i), 1'b0);
        chk("restart_a", bus.tile_a_o, {32'h207, 32'h205, 32'h203, 32'h201});
        chk("restart_b", bus.tile_b_o, {32'h206, 32'h204, 32'h202, 32'h200});
        chk("restart_cnt", 128'(tile_cnt), 128'(1));
        check_all("restart");

        // async reset between edges with a tile valid
        for (int i = 0; i < 8; i++) beat($urandom, 1'b0);
        check_all("ar_pre");
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 128'(bus.tile_valid_o), 128'(0));
        chk("ar_stall", 128'(stall), 128'(0));
        chk("ar_cnt", 128'(tile_cnt), 128'(0));
        model_clear();
        #2;
        rst = 1'b0;
        idle(1'b0);
        check_all("ar_post");

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [1:0] f;
            f = ($urandom_range(0, 149) == 0) ? 2'b10 :
                (($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00);
            step(f, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) == 0));
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scnn_tile_collector.md
Name: scnn_tile_collector

Overview:
- Read-side counterpart of the SCNN load address generator. The generator issues the gemm4x4 load addresses; this block consumes the matching data-memory responses (rvalid/rdata).
- It de-interleaves the response stream into a 4x4 int8 A tile and a 4x4 int8 B tile. Complete tile pairs go to the MAC array through a valid/ready handshake.
- It sits between the LSU response path and the gemm datapath. It has a 2-entry ping-pong buffer and raises a stall back to the request side when both entries are full.

Parameters:
- DATA_W, 32, width of one memory response word (4 int8 elements).
- TILE_DIM, 4, rows per tile; also words per operand per tile.
- CNT_W, 16, width of the completed-tile counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- scnn_flag_i  in  2  2'b10 = start of gemm load; synchronous clear of all collector state. Other values have no effect here.
- gemm4x4_active_i  in  1  a gemm4x4 load phase is in progress.
- im2col_active_i  in  1  im2col load mode. Responses are not collected while this is high.
- data_rvalid_i  in  1  a memory response is valid this cycle.
- data_rdata_i  in  DATA_W  response data.
- tile_a_o  out  DATA_W*TILE_DIM  A tile. Row r = bits [32r+31:32r]; byte k of a row = column k.
- tile_b_o  out  DATA_W*TILE_DIM  B tile, same packing.
- tile_valid_o  out  1  head buffer entry holds a complete tile pair.
- tile_ready_i  in  1  consumer accepts the tile pair when valid&ready.
- stall_o  out  1  fill entry is occupied; the request side must hold further requests.
- tile_cnt_o  out  CNT_W  number of tile pairs completed since the last clear.
- overflow_o  out  1  sticky: a response arrived while stall_o was high.

Behaviour:
- Reset (async, rst=1): beat counter=0, wr_sel=0, rd_sel=0, both entries empty, tile_valid_o=0, stall_o=0, tile_cnt_o=0, overflow_o=0. Tile data registers are cleared to 0.
- Accepted beat: data_rvalid_i & gemm4x4_active_i & ~im2col_active_i & ~stall_o.
- Beat order per tile follows the address generator (B first, then alternating): beat 0=B row0, 1=A row0, 2=B row1, 3=A row1, ..., 6=B row3, 7=A row3.
  - Even beat 2r writes B row r of entry wr_sel.
  - Odd beat 2r+1 writes A row r of entry wr_sel.
- Beat counter is 3 bits and advances by 1 per accepted beat.
- On beat 7:
  - Counter wraps to 0.
  - Entry wr_sel is marked full.
  - wr_sel toggles.
  - tile_cnt_o increments, wrapping at 2^CNT_W.
- Output side:
  - tile_valid_o = entry rd_sel full.
  - tile_a_o/tile_b_o are driven combinationally from entry rd_sel.
  - On valid&ready, entry rd_sel is marked empty and rd_sel toggles.
- stall_o = entry wr_sel full; it is a registered-state function with no combinational path from inputs.
- Simultaneous completion on beat 7 and pop of the other entry in the same cycle: both take effect. Latency from the beat-7 response to tile_valid_o is 1 cycle when the buffer was empty.
- Response while stall_o=1:
  - Data is dropped and the counter does not advance.
  - overflow_o is set and held until rst or a scnn_flag_i clear.
- Response while gemm4x4_active_i=0 or im2col_active_i=1 is ignored without error; writeback and maxpool traffic share the bus.
- scnn_flag_i==2'b10 has the highest synchronous priority. It clears the counter, both entries, wr_sel/rd_sel, tile_cnt_o and overflow_o. A partial tile is discarded, and any response in the same cycle is dropped.
- gemm4x4_active_i falling mid-tile: the partial beats are retained and collection resumes when the signal is high again.
- rst asserted mid-tile: immediate return to reset state.

Decomposition:
- Shared package scnn_pkg holds:
  - SCNN_FLAG_WB=2'b01 and SCNN_FLAG_LOAD=2'b10;
  - TILE_DIM and BEATS_PER_TILE=2*TILE_DIM;
  - the typedef tile_t = logic [TILE_DIM-1:0][DATA_W-1:0].
- One natural sub-module: scnn_tile_pingpong, a 2-entry tile store with full flags, wr_sel/rd_sel and the push/pop handshake.
- The top level keeps the beat counter, de-interleave, counters and error logic.

Test Plan:
- Single tile:
  - Stimulus: flag 2'b10, then 8 beats with rdata 0x000000B0,0x000000A0,0x000000B1,0x000000A1,...,0x000000A3, ready=1.
  - Response: one cycle after beat 7, tile_valid_o=1 with tile_b_o rows = B0..B3 and tile_a_o rows = A0..A3; tile_cnt_o=1.
- Back-pressure:
  - Stimulus: ready=0, stream 16 beats.
  - Response: after beat 15, stall_o=1; beat 16 sets overflow_o=1 and changes no data.
  - Then ready=1 for 2 cycles: two tiles pop in order, stall_o drops after the first pop, overflow_o stays 1.
- Simultaneous:
  - Stimulus: entry 0 full, ready=1 held, beat 7 of the next tile in the same cycle as the pop.
  - Response: tile 0 pops and tile 1 appears the next cycle; no lost or duplicated tile.
- Filtering:
  - Stimulus: rvalid with gemm4x4_active_i=0, then with im2col_active_i=1.
  - Response: beat counter unchanged, no tile, overflow_o=0.
- Restart:
  - Stimulus: 5 beats, then flag 2'b10 with rvalid in the same cycle, then 8 fresh beats.
  - Response: the tile contains only the fresh beats; tile_cnt_o=1.
- Async reset:
  - Stimulus: assert rst between clock edges with a tile valid.
  - Response: tile_valid_o, stall_o and tile_cnt_o go to 0 immediately, without waiting for a clock edge.
